// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with one-deep skid buffer and flush
// EX always sees the main entry; the skid entry only absorbs one instruction while EX stalls.

module id_ex_reg #(
   parameter int          DATA_W    = 32,
   parameter logic [4:0]  ALU_NO_OP = 5'd0
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              id_valid_i,
   output logic              id_ready_o,
   input  logic [DATA_W-1:0] id_pc_i,
   input  logic [DATA_W-1:0] id_rs1_data_i,
   input  logic [DATA_W-1:0] id_rs2_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [4:0]        id_rd_addr_i,
   input  logic [4:0]        id_rs1_addr_i,
   input  logic [4:0]        id_rs2_addr_i,
   input  logic [4:0]        cu_ALUctrl_i,
   input  logic              cu_reg_we_i,

   input  logic              ctrl_flush_i,

   input  logic              ex_ready_i,
   output logic              ex_valid_o,
   output logic [DATA_W-1:0] ex_pc_o,
   output logic [DATA_W-1:0] ex_rs1_data_o,
   output logic [DATA_W-1:0] ex_rs2_data_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [4:0]        ex_rd_addr_o,
   output logic [4:0]        ex_rs1_addr_o,
   output logic [4:0]        ex_rs2_addr_o,
   output logic [4:0]        ex_ALUctrl_o,
   output logic              ex_reg_we_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] rs1_data;
      logic [DATA_W-1:0] rs2_data;
      logic [DATA_W-1:0] imm;
      logic [4:0]        rd_addr;
      logic [4:0]        rs1_addr;
      logic [4:0]        rs2_addr;
      logic [4:0]        alu_ctrl;
      logic              reg_we;
   } entry_t;

   state_t state;
   entry_t main_q;
   entry_t skid_q;
   entry_t in_d;
   logic   ready_q;
   logic   valid_q;
   logic   accept;
   logic   fire;

   // Turning the main entry into a bubble keeps stale data but kills its side effects.
   function automatic entry_t make_bubble(input entry_t e);
      entry_t b;
      b          = e;
      b.alu_ctrl = ALU_NO_OP;
      b.reg_we   = 1'b0;
      return b;
   endfunction

   function automatic entry_t reset_entry();
      entry_t r;
      r          = '0;
      r.alu_ctrl = ALU_NO_OP;
      return r;
   endfunction

   always_comb begin
      in_d          = '0;
      in_d.pc       = id_pc_i;
      in_d.rs1_data = id_rs1_data_i;
      in_d.rs2_data = id_rs2_data_i;
      in_d.imm      = id_imm_i;
      in_d.rd_addr  = id_rd_addr_i;
      in_d.rs1_addr = id_rs1_addr_i;
      in_d.rs2_addr = id_rs2_addr_i;
      in_d.alu_ctrl = cu_ALUctrl_i;
      in_d.reg_we   = cu_reg_we_i;
   end

   assign accept = id_valid_i & ready_q & ~ctrl_flush_i;
   assign fire   = valid_q & ex_ready_i;

   // Handshake flags are registered alongside state so neither depends on ex_ready_i.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         main_q  <= reset_entry();
         skid_q  <= '0;
      end else if (ctrl_flush_i) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         main_q  <= make_bubble(main_q);
         skid_q  <= make_bubble(skid_q);
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state   <= ONE;
                  valid_q <= 1'b1;
                  main_q  <= in_d;
               end
            end
            ONE: begin
               if (accept && fire) begin
                  main_q <= in_d;
               end else if (accept) begin
                  state   <= TWO;
                  ready_q <= 1'b0;
                  skid_q  <= in_d;
               end else if (fire) begin
                  state   <= EMPTY;
                  valid_q <= 1'b0;
                  main_q  <= make_bubble(main_q);
               end
            end
            TWO: begin
               if (fire) begin
                  state   <= ONE;
                  ready_q <= 1'b1;
                  main_q  <= skid_q;
               end
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
               main_q  <= make_bubble(main_q);
            end
         endcase
      end
   end

   assign id_ready_o    = ready_q;
   assign ex_valid_o    = valid_q;
   assign ex_pc_o       = main_q.pc;
   assign ex_rs1_data_o = main_q.rs1_data;
   assign ex_rs2_data_o = main_q.rs2_data;
   assign ex_imm_o      = main_q.imm;
   assign ex_rd_addr_o  = main_q.rd_addr;
   assign ex_rs1_addr_o = main_q.rs1_addr;
   assign ex_rs2_addr_o = main_q.rs2_addr;
   assign ex_ALUctrl_o  = main_q.alu_ctrl;
   assign ex_reg_we_o   = main_q.reg_we;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of PC, operand and immediate fields.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 id_valid_i  in  1  ID presents a decoded instruction this cycle.
REQ-005 id_ready_o  out  1  block can accept an instruction this cycle.
REQ-006 id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  in  DATA_W each  PC, operands, immediate from ID.
REQ-007 id_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i  in  5 each  register addresses from ID.
REQ-008 cu_ALUctrl_i  in  5  ALU operation code from the control unit (`define.v` encodings).
REQ-009 cu_reg_we_i  in  1  register write enable from the control unit.
REQ-010 ctrl_flush_i  in  1  branch/jump flush request; kills all held and incoming instructions.
REQ-011 ex_ready_i  in  1  EX accepts the presented instruction this cycle.
REQ-012 ex_valid_o  out  1  an instruction is presented to EX.
REQ-013 ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  DATA_W each  registered copies for EX.
REQ-014 ex_rd_addr_o, ex_rs1_addr_o, ex_rs2_addr_o  out  5 each  registered addresses for EX.
REQ-015 ex_ALUctrl_o  out  5  registered ALU code; ex_reg_we_o  out  1  registered write enable.

Function
REQ-016 Block SHALL be a two-entry pipeline register (main + skid) with states EMPTY, ONE, TWO, encoded in a registered state variable.
REQ-017 accept = id_valid_i & id_ready_o & ~ctrl_flush_i; fire = ex_valid_o & ex_ready_i.
REQ-018 id_ready_o SHALL be 1 in EMPTY and ONE, 0 in TWO, decoded from registered state only (no combinational path from ex_ready_i).
REQ-019 ex_valid_o SHALL be 1 in ONE and TWO, 0 in EMPTY; outputs always driven from the main entry.
REQ-020 EMPTY: accept -> ONE, main loaded; else stay.
REQ-021 ONE: accept & fire -> ONE, main reloaded with input; accept & ~fire -> TWO, skid loaded, main held; ~accept & fire -> EMPTY; neither -> hold.
REQ-022 TWO: fire -> ONE, main loaded from skid; ~fire -> hold; no input accepted.
REQ-023 ctrl_flush_i=1 SHALL override all transitions: next state EMPTY, incoming instruction dropped, both entries invalidated, regardless of ex_ready_i.
REQ-024 Whenever ex_valid_o=0, ex_ALUctrl_o SHALL read `NO_OP and ex_reg_we_o SHALL read 0 (bubble); other data outputs are don't-care but SHALL retain their last value.
REQ-025 Latency: instruction accepted at edge N appears on outputs after edge N (1 cycle) when the block was EMPTY or firing.
REQ-026 Ordering SHALL be strictly FIFO; no instruction duplicated or lost except by flush.
REQ-027 Held output fields SHALL remain stable while ex_valid_o=1 and ex_ready_i=0.

Reset
REQ-028 While rst=1: state EMPTY, id_ready_o=1, ex_valid_o=0, ex_ALUctrl_o=`NO_OP, ex_reg_we_o=0, all other outputs and skid contents 0, asynchronously.
REQ-029 Reset deassertion mid-operation SHALL restart from EMPTY; held instructions are discarded.

Verification
REQ-030 Streaming: ex_ready_i=1, id_valid_i=1, PCs 0x00,0x04,0x08 on consecutive cycles -> ex_pc_o 0x00,0x04,0x08 one cycle later, ex_valid_o=1 continuous, id_ready_o=1 throughout.
REQ-031 Backpressure: ex_ready_i=0, send PC 0x10 then 0x14 -> state TWO, id_ready_o=0, ex_pc_o=0x10 held; raise ex_ready_i for 2 cycles -> 0x10 then 0x14 delivered, then EMPTY.
REQ-032 Flush: state TWO holding 0x20,0x24, id_valid_i=1 with 0x28 and ctrl_flush_i=1 -> next cycle ex_valid_o=0, ex_ALUctrl_o=`NO_OP, ex_reg_we_o=0, id_ready_o=1; 0x28 never appears.
REQ-033 Bubble: id_valid_i=0 for 3 cycles with ex_ready_i=1 -> ex_valid_o=0, ex_reg_we_o=0 for all 3 cycles.
REQ-034 Field pass-through: rd=5'd7, cu_ALUctrl_i=`SUB, cu_reg_we_i=1, imm=0xFFFFF800 -> identical values on ex_* outputs next cycle.
REQ-035 Async reset: assert rst between edges while in ONE -> ex_valid_o=0 immediately without a clock edge; after release, first accepted PC 0x40 appears one cycle later.
